tstate_seq: RTL

//   Parametrised T-state sequencer; successor to the fixed 3-bit T-state counter.

---
 rtl/tstate_pkg.sv | 8 +
 rtl/step_sync.sv | 24 ++
 rtl/tstate_seq.sv | 64 ++++++
 3 files changed

// File: rtl/tstate_pkg.sv
// Shared T-state constants for the sequencer and the microcode decode.
package tstate_pkg;
  localparam int unsigned NUM_T_DEF = 8;
  localparam int unsigned TW_DEF    = 3;
  localparam int unsigned CW_DEF    = 16;
  localparam int unsigned T_FETCH0  = 0;
  localparam int unsigned T_FETCH1  = 1;
endpackage

// File: rtl/step_sync.sv
// Two-flop synchroniser for the asynchronous step button, followed by a
// rising-edge detector giving a one-clock step pulse (falling-edge domain).
module step_sync (
  input  logic clk,
  input  logic reset_bar,
  input  logic step_req,
  output logic step_pulse
);
  logic sync1, sync2, prev;

  always_ff @(negedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= step_req;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign step_pulse = sync2 & ~prev;
endmodule

// File: rtl/tstate_seq.sv
// Parametrised T-state sequencer: counts T-states on the falling clock edge,
// with hold, single-step, end-of-instruction clear and an instruction counter.
module tstate_seq
  import tstate_pkg::*;
#(
  parameter int unsigned NUM_T = NUM_T_DEF,
  parameter int unsigned TW    = TW_DEF,
  parameter int unsigned CW    = CW_DEF
) (
  input  logic             clk,
  input  logic             reset_bar,
  input  logic             clr,
  input  logic             hold,
  input  logic             step_en,
  input  logic             step_req,
  output logic [TW-1:0]    T,
  output logic [NUM_T-1:0] T_onehot,
  output logic             T_last,
  output logic             wrap,
  output logic [CW-1:0]    instr_count
);
  localparam logic [TW-1:0] T_MAX = TW'(NUM_T - 1);

  logic step_pulse;
  logic adv;

  step_sync u_step_sync (
    .clk       (clk),
    .reset_bar (reset_bar),
    .step_req  (step_req),
    .step_pulse(step_pulse)
  );

  // hold dominates; in step mode only a synchronised press may advance
  assign adv = !hold && (!step_en || step_pulse);

  always_ff @(negedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      T           <= '0;
      wrap        <= 1'b0;
      instr_count <= '0;
    end else if (adv) begin
      if (clr || T == T_MAX) begin
        T           <= '0;
        wrap        <= 1'b1;
        instr_count <= instr_count + CW'(1);
      end else begin
        T    <= T + TW'(1);
        wrap <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

  always_comb begin
    T_onehot = '0;
    for (int unsigned i = 0; i < NUM_T; i++) begin
      T_onehot[i] = (T == TW'(i));
    end
  end

  assign T_last = (T == T_MAX);
endmodule
